// File: rtl/multi_controller.sv
// ----------------------------------------------------------------------------
// multi_controller
//
// Main control FSM and ALU decoder for a multi-cycle MIPS datapath. Each
// instruction runs through FETCH and DECODE and then its own execute, memory
// and writeback states. The block drives every datapath mux select and
// enable, plus the ALU operation code.
//
// Optional feature (compile-time macro MULTI_IMM_LOGIC_EN):
//   defined   - andi / ori / slti are decoded as immediate ALU instructions
//               and imm_zext_o selects zero extension for andi / ori.
//   undefined - those opcodes are treated as illegal (NOP) and imm_zext_o
//               is constant 0.
//
// Ports:
//   clk_i          in   1  clock, rising edge
//   rst_i          in   1  synchronous active-high reset
//   opcode_i       in   6  instr[31:26] from the instruction register
//   funct_i        in   6  instr[5:0] from the instruction register
//   zero_i         in   1  ALU zero flag
//   pc_write_o     out  1  PC enable (unconditional or branch taken)
//   iord_o         out  1  memory address: 0=PC, 1=ALUOut
//   mem_write_o    out  1  data memory write strobe
//   ir_write_o     out  1  instruction register enable
//   reg_dst_o      out  1  write register: 0=rt, 1=rd
//   mem_to_reg_o   out  1  writeback data: 0=ALUOut, 1=memory data
//   reg_write_o    out  1  register file write enable
//   alu_src_a_o    out  2  A: 0=PC, 1=reg A, 2=shamt
//   alu_src_b_o    out  2  B: 0=reg B, 1=4, 2=ext imm, 3=sign imm<<2
//   imm_zext_o     out  1  immediate extension: 0=sign, 1=zero
//   pc_src_o       out  2  next PC: 0=ALU result, 1=ALUOut, 2=jump target
//   alu_control_o  out  3  000 and,001 or,010 add,011 sll,100 srl,
//                          101 sra,110 sub,111 slt
//   state_o        out  4  current FSM state (debug observation)
// ----------------------------------------------------------------------------
module multi_controller #(
    parameter int OpWidth    = 6,
    parameter int FunctWidth = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [OpWidth-1:0]    opcode_i,
    input  logic [FunctWidth-1:0] funct_i,
    input  logic                  zero_i,
    output logic                  pc_write_o,
    output logic                  iord_o,
    output logic                  mem_write_o,
    output logic                  ir_write_o,
    output logic                  reg_dst_o,
    output logic                  mem_to_reg_o,
    output logic                  reg_write_o,
    output logic [1:0]            alu_src_a_o,
    output logic [1:0]            alu_src_b_o,
    output logic                  imm_zext_o,
    output logic [1:0]            pc_src_o,
    output logic [2:0]            alu_control_o,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OpWidth-1:0] OP_RTYPE = OpWidth'(6'b000000);
    localparam logic [OpWidth-1:0] OP_J     = OpWidth'(6'b000010);
    localparam logic [OpWidth-1:0] OP_BEQ   = OpWidth'(6'b000100);
    localparam logic [OpWidth-1:0] OP_BNE   = OpWidth'(6'b000101);
    localparam logic [OpWidth-1:0] OP_ADDI  = OpWidth'(6'b001000);
    localparam logic [OpWidth-1:0] OP_LW    = OpWidth'(6'b100011);
    localparam logic [OpWidth-1:0] OP_SW    = OpWidth'(6'b101011);
`ifdef MULTI_IMM_LOGIC_EN
    localparam logic [OpWidth-1:0] OP_SLTI  = OpWidth'(6'b001010);
    localparam logic [OpWidth-1:0] OP_ANDI  = OpWidth'(6'b001100);
    localparam logic [OpWidth-1:0] OP_ORI   = OpWidth'(6'b001101);
`endif

    localparam logic [FunctWidth-1:0] FN_SLL = FunctWidth'(6'b000000);
    localparam logic [FunctWidth-1:0] FN_SRL = FunctWidth'(6'b000010);
    localparam logic [FunctWidth-1:0] FN_SRA = FunctWidth'(6'b000011);
    localparam logic [FunctWidth-1:0] FN_ADD = FunctWidth'(6'b100000);
    localparam logic [FunctWidth-1:0] FN_SUB = FunctWidth'(6'b100010);
    localparam logic [FunctWidth-1:0] FN_AND = FunctWidth'(6'b100100);
    localparam logic [FunctWidth-1:0] FN_OR  = FunctWidth'(6'b100101);
    localparam logic [FunctWidth-1:0] FN_SLT = FunctWidth'(6'b101010);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // R-type decode result: {known funct, shift (A from shamt), alu op}
    function automatic logic [4:0] r_decode(input logic [FunctWidth-1:0] f);
        case (f)
            FN_ADD:  r_decode = {1'b1, 1'b0, ALU_ADD};
            FN_SUB:  r_decode = {1'b1, 1'b0, ALU_SUB};
            FN_AND:  r_decode = {1'b1, 1'b0, ALU_AND};
            FN_OR:   r_decode = {1'b1, 1'b0, ALU_OR};
            FN_SLT:  r_decode = {1'b1, 1'b0, ALU_SLT};
            FN_SLL:  r_decode = {1'b1, 1'b1, ALU_SLL};
            FN_SRL:  r_decode = {1'b1, 1'b1, ALU_SRL};
            FN_SRA:  r_decode = {1'b1, 1'b1, ALU_SRA};
            default: r_decode = {1'b0, 1'b0, ALU_ADD};
        endcase
    endfunction

    // Immediate-instruction decode result: {legal, zero-extend, alu op}
    function automatic logic [4:0] imm_decode(input logic [OpWidth-1:0] op);
        case (op)
            OP_ADDI: imm_decode = {1'b1, 1'b0, ALU_ADD};
`ifdef MULTI_IMM_LOGIC_EN
            OP_ANDI: imm_decode = {1'b1, 1'b1, ALU_AND};
            OP_ORI:  imm_decode = {1'b1, 1'b1, ALU_OR};
            OP_SLTI: imm_decode = {1'b1, 1'b0, ALU_SLT};
`endif
            default: imm_decode = {1'b0, 1'b0, ALU_ADD};
        endcase
    endfunction

    state_t     state_q;
    state_t     state_d;
    logic [4:0] r_info;
    logic [4:0] imm_info;

    assign r_info   = r_decode(funct_i);
    assign imm_info = imm_decode(opcode_i);
    assign state_o  = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        pc_write_o    = 1'b0;
        iord_o        = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        reg_write_o   = 1'b0;
        alu_src_a_o   = 2'd0;
        alu_src_b_o   = 2'd0;
        imm_zext_o    = 1'b0;
        pc_src_o      = 2'd0;
        alu_control_o = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                ir_write_o  = 1'b1;
                alu_src_b_o = 2'd1;
                pc_write_o  = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b_o = 2'd3;
                if (opcode_i == OP_LW || opcode_i == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode_i == OP_RTYPE) begin
                    state_d = S_EXECUTE;
                end else if (opcode_i == OP_BEQ || opcode_i == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (opcode_i == OP_J) begin
                    state_d = S_JUMP;
                end else if (imm_info[4]) begin
                    state_d = S_IMMEXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd2;
                state_d     = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord_o  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
            end
            S_MEMWR: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_o   = r_info[3] ? 2'd2 : 2'd1;
                alu_control_o = r_info[2:0];
                // An unknown funct is dropped without a register write.
                state_d       = r_info[4] ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o   = 2'd1;
                alu_control_o = ALU_SUB;
                pc_src_o      = 2'd1;
                pc_write_o    = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
            end
            S_IMMEXEC: begin
                alu_src_a_o   = 2'd1;
                alu_src_b_o   = 2'd2;
                imm_zext_o    = imm_info[3];
                alu_control_o = imm_info[2:0];
                state_d       = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write_o = 1'b1;
            end
            S_JUMP: begin
                pc_src_o   = 2'd2;
                pc_write_o = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset aborts whatever is in flight: no write of any kind this cycle.
        if (rst_i) begin
            pc_write_o    = 1'b0;
            iord_o        = 1'b0;
            mem_write_o   = 1'b0;
            ir_write_o    = 1'b0;
            reg_dst_o     = 1'b0;
            mem_to_reg_o  = 1'b0;
            reg_write_o   = 1'b0;
            alu_src_a_o   = 2'd0;
            alu_src_b_o   = 2'd0;
            imm_zext_o    = 1'b0;
            pc_src_o      = 2'd0;
            alu_control_o = ALU_ADD;
        end
    end

endmodule

// File: tb/tb_multi_controller.sv
module tb_multi_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pc_write, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic [1:0] alu_src_a, alu_src_b, pc_src;
    logic       imm_zext;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;

    int compared   = 0;
    int mismatched = 0;

`ifdef MULTI_IMM_LOGIC_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    multi_controller #(.OpWidth(6), .FunctWidth(6)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .zero_i       (zero),
        .pc_write_o   (pc_write),
        .iord_o       (iord),
        .mem_write_o  (mem_write),
        .ir_write_o   (ir_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .reg_write_o  (reg_write),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .imm_zext_o   (imm_zext),
        .pc_src_o     (pc_src),
        .alu_control_o(alu_control),
        .state_o      (state_dbg)
    );

    // Observed control word:
    // {pc_write,iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
    //  src_a[2],src_b[2],imm_zext,pc_src[2],alu[3]}
    logic [16:0] obs;
    assign obs = {pc_write, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, imm_zext, pc_src, alu_control};

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];
    string       tag_q[$];

    function automatic logic [16:0] mk(input bit pcw, input bit io, input bit mw,
                                       input bit irw, input bit rd, input bit m2r,
                                       input bit rw, input logic [1:0] sa,
                                       input logic [1:0] sb, input bit zx,
                                       input logic [1:0] ps, input logic [2:0] alu);
        return {pcw, io, mw, irw, rd, m2r, rw, sa, sb, zx, ps, alu};
    endfunction

    task automatic push(input string tag, input logic [16:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input string tag, input logic [16:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
        end
    endtask

    task automatic check_enables(input string tag);
        compared++;
        assert ({pc_write, mem_write, ir_write, reg_write} === 4'b0000) else begin
            mismatched++;
            $error("FAIL %s observed_en=%b expected_en=0000", tag,
                   {pc_write, mem_write, ir_write, reg_write});
        end
    endtask

    // ---------------- reference model ----------------
    // Builds the per-cycle control words an instruction must produce,
    // straight from the instruction-level behaviour.
    task automatic plan(input logic [5:0] op, input logic [5:0] fn, input bit z);
        logic [2:0] alu;
        bit         known;
        bit         shift;
        bit         taken;
        push("fetch",  mk(1,0,0,1,0,0,0, 2'd0, 2'd1, 0, 2'd0, 3'b010));
        push("decode", mk(0,0,0,0,0,0,0, 2'd0, 2'd3, 0, 2'd0, 3'b010));
        case (op)
            6'b100011: begin
                push("lw_addr", mk(0,0,0,0,0,0,0, 2'd1, 2'd2, 0, 2'd0, 3'b010));
                push("lw_read", mk(0,1,0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 3'b010));
                push("lw_wb",   mk(0,0,0,0,0,1,1, 2'd0, 2'd0, 0, 2'd0, 3'b010));
            end
            6'b101011: begin
                push("sw_addr",  mk(0,0,0,0,0,0,0, 2'd1, 2'd2, 0, 2'd0, 3'b010));
                push("sw_write", mk(0,1,1,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 3'b010));
            end
            6'b000000: begin
                known = 1'b1;
                shift = 1'b0;
                case (fn)
                    6'b100000: alu = 3'b010;
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    6'b000000: begin alu = 3'b011; shift = 1'b1; end
                    6'b000010: begin alu = 3'b100; shift = 1'b1; end
                    6'b000011: begin alu = 3'b101; shift = 1'b1; end
                    default:   begin alu = 3'b010; known = 1'b0; end
                endcase
                push("r_exec", mk(0,0,0,0,0,0,0, shift ? 2'd2 : 2'd1, 2'd0, 0, 2'd0, alu));
                if (known)
                    push("r_wb", mk(0,0,0,0,1,0,1, 2'd0, 2'd0, 0, 2'd0, 3'b010));
            end
            6'b000100, 6'b000101: begin
                taken = (op == 6'b000100) ? z : !z;
                push("branch", mk(taken,0,0,0,0,0,0, 2'd1, 2'd0, 0, 2'd1, 3'b110));
            end
            6'b000010: push("jump", mk(1,0,0,0,0,0,0, 2'd0, 2'd0, 0, 2'd2, 3'b010));
            6'b001000: begin
                push("imm_exec", mk(0,0,0,0,0,0,0, 2'd1, 2'd2, 0, 2'd0, 3'b010));
                push("imm_wb",   mk(0,0,0,0,0,0,1, 2'd0, 2'd0, 0, 2'd0, 3'b010));
            end
            6'b001100, 6'b001101, 6'b001010: begin
                if (IMM_EN) begin
                    alu = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 : 3'b111;
                    push("imm_exec", mk(0,0,0,0,0,0,0, 2'd1, 2'd2, op != 6'b001010,
                                        2'd0, alu));
                    push("imm_wb",   mk(0,0,0,0,0,0,1, 2'd0, 2'd0, 0, 2'd0, 3'b010));
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- driver ----------------
    // Entered and left at a falling edge with the DUT sitting in FETCH.
    task automatic run_instr(input string name, input logic [5:0] op,
                             input logic [5:0] fn, input bit z);
        logic [16:0] v;
        string       t;
        opcode = op;
        funct  = fn;
        zero   = z;
        plan(op, fn, z);
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            t = tag_q.pop_front();
            #1 check({name, "/", t}, v);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Start an instruction, let it run n cycles, then reset in the middle.
    task automatic reset_at(input string name, input logic [5:0] op,
                            input logic [5:0] fn, input bit z, input int n);
        opcode = op;
        funct  = fn;
        zero   = z;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1 check_enables({name, "/rst_abort"});
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check({name, "/rst_fetch"}, mk(1,0,0,1,0,0,0, 2'd0, 2'd1, 0, 2'd0, 3'b010));
    endtask

    logic [5:0] op_pool[13];
    logic [5:0] fn_pool[8];

    initial begin
        op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b000101,
                    6'b001000, 6'b000010, 6'b001100, 6'b001101, 6'b001010, 6'b111111,
                    6'b000000};
        fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                    6'b000000, 6'b000010, 6'b000011};

        rst = 1'b1;
        @(negedge clk);
        #1 check_enables("reset_hold");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_instr("lw",      6'b100011, 6'd0,      1'b0);
        run_instr("sw",      6'b101011, 6'd0,      1'b0);
        run_instr("sub",     6'b000000, 6'b100010, 1'b0);
        run_instr("sra",     6'b000000, 6'b000011, 1'b0);
        run_instr("sll",     6'b000000, 6'b000000, 1'b0);
        run_instr("slt",     6'b000000, 6'b101010, 1'b0);
        run_instr("bad_fn",  6'b000000, 6'b111111, 1'b0);
        run_instr("beq_z1",  6'b000100, 6'd0,      1'b1);
        run_instr("beq_z0",  6'b000100, 6'd0,      1'b0);
        run_instr("bne_z1",  6'b000101, 6'd0,      1'b1);
        run_instr("bne_z0",  6'b000101, 6'd0,      1'b0);
        run_instr("illegal", 6'b111111, 6'd0,      1'b0);
        run_instr("addi",    6'b001000, 6'd0,      1'b0);
        run_instr("ori",     6'b001101, 6'd0,      1'b0);
        run_instr("andi",    6'b001100, 6'd0,      1'b0);
        run_instr("slti",    6'b001010, 6'd0,      1'b0);
        run_instr("j",       6'b000010, 6'd0,      1'b0);

        reset_at("rst_lw_wb",  6'b100011, 6'd0,      1'b0, 4);
        reset_at("rst_jump",   6'b000010, 6'd0,      1'b0, 2);
        reset_at("rst_sw_wr",  6'b101011, 6'd0,      1'b0, 3);
        reset_at("rst_r_wb",   6'b000000, 6'b100000, 1'b0, 3);
        reset_at("rst_fetch",  6'b000000, 6'b100000, 1'b0, 0);

        for (int i = 0; i < 200; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = op_pool[$urandom_range(0, 12)];
            if ($urandom_range(0, 5) == 0) op = 6'($urandom_range(0, 63));
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : fn_pool[$urandom_range(0, 7)];
            run_instr("rand", op, fn, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
